com_uart: RTL and testbench

//  COM-bus responder for the risc8 core: UART (8N1, LSB first) at 4 COM addresses.
//  CPU writes DATA to queue TX bytes, reads DATA/STATUS, writes CTRL/STATUS.

---
 rtl/com_uart.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_com_uart.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/com_uart.sv
// ---------------------------------------------------------------------------
// com_uart -- COM-bus UART responder (8N1, LSB first) for the risc8 core.
//
// Register map (relative to BASE_ADDR):
//   +0 DATA    write: queue a TX byte   read: RX holding byte
//   +1 STATUS  [0] txf_empty [1] txf_full [2] tx_busy [3] rx_valid
//              [4] rx_ovr    [5] rx_fe    [6] tx_ovf  [7] 0
//              write 1s to [6:4] to clear those flags
//   +2 CTRL    [0] rx irq enable [1] tx-done irq enable
//   +3 reserved, reads 0
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   com_addr   register address
//   com_wr     write data, qualified by com_we
//   com_we     write strobe
//   com_re     read strobe, only used for the DATA pop side effect
//   com_rd     combinational read data (cause byte while interrupt=1)
//   interrupt  one-cycle interrupt pulse
//   uart_tx    serial output, idle high
//   uart_rx    serial input, asynchronous
//
// Build option: define COM_UART_RX_EN to include the receiver. Without it
// uart_rx is ignored, DATA reads 0 and STATUS[5:3] read 0.
//
// Bus handshake: com_we and com_re are single-cycle strobes qualified by
// com_addr in the same cycle; the block never stalls the bus, so every
// strobe is consumed at the clock edge that samples it.
// ---------------------------------------------------------------------------
module com_uart #(
    parameter logic [7:0]  BASE_ADDR  = 8'h04,
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [3:0]  IRQ_ID     = 4'h1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] com_addr,
    input  logic [7:0] com_wr,
    input  logic       com_we,
    input  logic       com_re,
    output logic [7:0] com_rd,
    output logic       interrupt,
    output logic       uart_tx,
    input  logic       uart_rx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_data, sel_stat, sel_ctrl;
    assign sel_data = (com_addr == BASE_ADDR);
    assign sel_stat = (com_addr == BASE_ADDR + 8'd1);
    assign sel_ctrl = (com_addr == BASE_ADDR + 8'd2);

    // ------------------------------------------------------------------
    // TX FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [7:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic fifo_empty, fifo_full, tx_pop, push_req, push_ok, ovf_set;
    logic [7:0] fifo_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign push_req   = com_we & sel_data;
    // A full FIFO still takes the byte if the TX engine frees a slot now.
    assign push_ok    = push_req & (~fifo_full | tx_pop);
    assign ovf_set    = push_req & fifo_full & ~tx_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q[AW-1:0]] <= com_wr;
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_busy, tx_baud_done, tx_done_evt;

    assign tx_baud_done = (tx_cnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_head;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_baud_done) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_baud_done) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    else                  tx_bit_d   = tx_bit_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_baud_done) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_head;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        unique case (tx_state_q)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift_q[0];
            default:  uart_tx = 1'b1;
        endcase
        tx_busy = (tx_state_q != TX_IDLE);
    end

    // Leaving STOP for IDLE is the only busy 1->0 transition, and it only
    // happens with the FIFO empty.
    assign tx_done_evt = (tx_state_q == TX_STOP) && (tx_state_d == TX_IDLE);

    // ------------------------------------------------------------------
    // CTRL and tx overflow flag
    // ------------------------------------------------------------------
    logic [1:0] ctrl_q;
    logic       tx_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            tx_ovf_q <= 1'b0;
        end else begin
            if (com_we && sel_ctrl) ctrl_q <= com_wr[1:0];
            if (ovf_set)                           tx_ovf_q <= 1'b1;
            else if (com_we && sel_stat && com_wr[6]) tx_ovf_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic       rx_valid, rx_ovr, rx_fe, rx_cause;
    logic [7:0] rx_data;

`ifdef COM_UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, rx_ovr_q, rx_fe_q;
    logic          rx_stop_sample, rx_pop, rx_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // Re-check half a bit later; a high line means a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_stop_sample = (rx_state_q == RX_STOP) && (rx_cnt_q == DIV_LAST);
    end

    assign rx_pop  = com_re & sel_data;
    assign rx_load = rx_stop_sample & rx_sync_q & (~rx_valid_q | rx_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_fe_q    <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (rx_pop) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_stop_sample && rx_sync_q && rx_valid_q && !rx_pop)
                rx_ovr_q <= 1'b1;
            else if (com_we && sel_stat && com_wr[4])
                rx_ovr_q <= 1'b0;
            if (rx_stop_sample && !rx_sync_q)
                rx_fe_q <= 1'b1;
            else if (com_we && sel_stat && com_wr[5])
                rx_fe_q <= 1'b0;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_ovr   = rx_ovr_q;
    assign rx_fe    = rx_fe_q;
    assign rx_data  = rx_data_q;
    // Only a 0->1 change of rx_valid is a cause; a refill keeps valid high.
    assign rx_cause = rx_load & ~rx_valid_q & ctrl_q[0];
`else
    logic unused_rx_inputs;
    assign unused_rx_inputs = ^{uart_rx, com_re};
    assign rx_valid = 1'b0;
    assign rx_ovr   = 1'b0;
    assign rx_fe    = 1'b0;
    assign rx_data  = 8'h00;
    assign rx_cause = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Interrupt pulse and cause capture
    // ------------------------------------------------------------------
    logic       irq_q, cause_tx;
    logic [1:0] cause_q;

    assign cause_tx = tx_done_evt & ctrl_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            irq_q   <= cause_tx | rx_cause;
            cause_q <= {cause_tx, rx_cause};
        end
    end

    assign interrupt = irq_q;

    // ------------------------------------------------------------------
    // Read mux; the cause byte overrides the address during the pulse
    // ------------------------------------------------------------------
    logic [7:0] status;
    assign status = {1'b0, tx_ovf_q, rx_fe, rx_ovr, rx_valid,
                     tx_busy, fifo_full, fifo_empty};

    always_comb begin
        com_rd = 8'h00;
        if (irq_q)         com_rd = {IRQ_ID, 2'b00, cause_q};
        else if (sel_data) com_rd = rx_data;
        else if (sel_stat) com_rd = status;
        else if (sel_ctrl) com_rd = {6'b0, ctrl_q};
    end

endmodule

// File: tb/tb_com_uart.sv
module tb_com_uart;

  localparam logic [7:0] BASE   = 8'h04;
  localparam int         DIV    = 4;
  localparam logic [7:0] A_DATA = BASE;
  localparam logic [7:0] A_STAT = BASE + 8'd1;
  localparam logic [7:0] A_CTRL = BASE + 8'd2;
  localparam logic [7:0] A_RSVD = BASE + 8'd3;
  localparam logic [1:0] S_RD   = 2'd0;
  localparam logic [1:0] S_TX   = 2'd1;
  localparam logic [1:0] S_IRQ  = 2'd2;

  logic       clk;
  logic       rst;
  logic [7:0] com_addr;
  logic [7:0] com_wr;
  logic       com_we;
  logic       com_re;
  logic [7:0] com_rd;
  logic       interrupt;
  logic       uart_tx;
  logic       uart_rx;

  com_uart #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (DIV),
    .FIFO_DEPTH(4),
    .IRQ_ID    (4'h1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .com_addr (com_addr),
    .com_wr   (com_wr),
    .com_we   (com_we),
    .com_re   (com_re),
    .com_rd   (com_rd),
    .interrupt(interrupt),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [1:0] sel_q[$];
  string      nm_q[$];
  logic [9:0] frame_q[$];
  logic [7:0] irq_exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       probe_v = 1'b0;
  logic       done_chk = 1'b0;
  logic       done_seen = 1'b0;

  logic       prev_irq = 1'b0;
  logic       prev_tx = 1'b1;
  logic       fr_act = 1'b0;
  int         fr_cnt = 0;
  int         fr_k = 0;
  logic [9:0] fr_bits = '0;
  logic [7:0] m_exp;
  logic [1:0] m_sel;
  string      m_nm;
  logic [7:0] m_act;

  function automatic void check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // monitor: probes, interrupt pulses, serial frames, leftovers
  always @(negedge clk) begin
    if (probe_v) begin
      m_exp = exp_q.pop_front();
      m_sel = sel_q.pop_front();
      m_nm  = nm_q.pop_front();
      case (m_sel)
        S_RD:    m_act = com_rd;
        S_TX:    m_act = {7'b0, uart_tx};
        default: m_act = {7'b0, interrupt};
      endcase
      check(m_nm, {2'b00, m_act}, {2'b00, m_exp});
    end

    if (interrupt) begin
      check("irq_width", {9'b0, prev_irq}, 10'd0);
      if (irq_exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL irq_unexpected: got cause %h expected no interrupt", com_rd);
      end else begin
        check("irq_cause", {2'b00, com_rd}, {2'b00, irq_exp_q.pop_front()});
      end
    end
    prev_irq = interrupt;

    if (rst) begin
      fr_act = 1'b0;
    end else if (!fr_act) begin
      if (prev_tx && !uart_tx) begin
        fr_act  = 1'b1;
        fr_cnt  = 0;
        fr_bits = '0;
      end
    end else begin
      fr_cnt++;
      if (fr_cnt >= DIV / 2 && (fr_cnt - DIV / 2) % DIV == 0) begin
        fr_k = (fr_cnt - DIV / 2) / DIV;
        fr_bits[fr_k] = uart_tx;
        if (fr_k == 9) begin
          fr_act = 1'b0;
          if (frame_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_frame_unexpected: got %h expected no frame", fr_bits);
          end else begin
            check("tx_frame", fr_bits, frame_q.pop_front());
          end
        end
      end
    end
    prev_tx = uart_tx;

    if (done_chk && !done_seen) begin
      done_seen = 1'b1;
      check("left_frames", 10'(frame_q.size()), 10'd0);
      check("left_irqs",   10'(irq_exp_q.size()), 10'd0);
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    com_addr = a;
    com_wr   = d;
    com_we   = 1'b1;
    @(posedge clk);
    #1;
    com_we   = 1'b0;
  endtask

  task automatic probe(input logic [1:0] sel, input logic [7:0] a, input logic re,
                       input logic [7:0] exp, input string nm);
    com_addr = a;
    com_re   = re;
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    nm_q.push_back(nm);
    probe_v  = 1'b1;
    @(posedge clk);
    #1;
    probe_v  = 1'b0;
    com_re   = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      idle(DIV);
    end
    uart_rx = 1'b1;
  endtask

  logic [7:0] burst_v[6];

  initial begin
    burst_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rst = 1'b1; com_addr = 8'h00; com_wr = 8'h00; com_we = 1'b0; com_re = 1'b0; uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    probe(S_RD, A_STAT, 1'b0, 8'h01, "rst_status");
    probe(S_RD, A_CTRL, 1'b0, 8'h00, "rst_ctrl");
    probe(S_RD, A_DATA, 1'b0, 8'h00, "rst_data");
    probe(S_RD, A_RSVD, 1'b0, 8'h00, "rsvd_reads0");
    probe(S_RD, 8'h00,  1'b0, 8'h00, "unmapped_reads0");
    probe(S_TX, A_STAT, 1'b0, 8'h01, "rst_uart_tx");
    probe(S_IRQ, A_STAT, 1'b0, 8'h00, "rst_interrupt");

    // CTRL upper bits read 0
    wr(A_CTRL, 8'hFF);
    probe(S_RD, A_CTRL, 1'b0, 8'h03, "ctrl_mask");
    wr(A_CTRL, 8'h02);

    // single byte: 2-cycle start latency, frame bits, tx-done irq
    frame_q.push_back({1'b1, 8'hA5, 1'b0});
    irq_exp_q.push_back(8'h12);
    wr(A_DATA, 8'hA5);
    probe(S_TX, A_STAT, 1'b0, 8'h01, "tx_idle_after_write");
    probe(S_TX, A_STAT, 1'b0, 8'h00, "tx_start_bit");
    probe(S_RD, A_STAT, 1'b0, 8'h05, "status_busy");
    idle(45);
    probe(S_RD, A_STAT, 1'b0, 8'h01, "status_done");

    // FIFO overflow while busy, W1C of tx_ovf, back-to-back frames
    frame_q.push_back({1'b1, 8'h11, 1'b0});
    wr(A_DATA, burst_v[0]);
    idle(3);
    for (int i = 1; i < 6; i++) begin
      if (i < 5) frame_q.push_back({1'b1, burst_v[i], 1'b0});
      wr(A_DATA, burst_v[i]);
    end
    irq_exp_q.push_back(8'h12);
    probe(S_RD, A_STAT, 1'b0, 8'h46, "status_full_ovf");
    wr(A_STAT, 8'h40);
    probe(S_RD, A_STAT, 1'b0, 8'h06, "status_ovf_cleared");
    idle(200);
    probe(S_RD, A_STAT, 1'b0, 8'h01, "status_burst_done");

    // reset mid-frame
    wr(A_DATA, 8'h5A);
    wr(A_DATA, 8'hC3);
    idle(10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    probe(S_TX, A_STAT, 1'b0, 8'h01, "midrst_uart_tx");
    probe(S_IRQ, A_STAT, 1'b0, 8'h00, "midrst_interrupt");
    probe(S_RD, A_STAT, 1'b0, 8'h01, "midrst_status");
    probe(S_RD, A_CTRL, 1'b0, 8'h00, "midrst_ctrl");
    idle(50);

`ifndef COM_UART_RX_EN
    // receiver absent: line activity has no effect
    wr(A_CTRL, 8'h01);
    send_rx(8'h3C, 1'b1);
    idle(6);
    probe(S_RD, A_STAT, 1'b0, 8'h01, "norx_status");
    probe(S_RD, A_DATA, 1'b1, 8'h00, "norx_data");
`else
    // single received byte with rx irq
    wr(A_CTRL, 8'h01);
    irq_exp_q.push_back(8'h11);
    send_rx(8'h3C, 1'b1);
    idle(6);
    probe(S_RD, A_STAT, 1'b0, 8'h09, "rx_status_valid");
    probe(S_RD, A_DATA, 1'b1, 8'h3C, "rx_data");
    probe(S_RD, A_STAT, 1'b0, 8'h01, "rx_valid_cleared");

    // overrun: second byte arrives before the first is read
    irq_exp_q.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    idle(6);
    probe(S_RD, A_STAT, 1'b0, 8'h19, "rx_status_ovr");
    probe(S_RD, A_DATA, 1'b1, 8'h11, "rx_data_kept");
    probe(S_RD, A_STAT, 1'b0, 8'h11, "rx_ovr_after_pop");
    wr(A_STAT, 8'h10);
    probe(S_RD, A_STAT, 1'b0, 8'h01, "rx_ovr_cleared");

    // framing error
    send_rx(8'h55, 1'b0);
    idle(6);
    probe(S_RD, A_STAT, 1'b0, 8'h21, "rx_status_fe");
    wr(A_STAT, 8'h20);
    probe(S_RD, A_STAT, 1'b0, 8'h01, "rx_fe_cleared");

    // false start: one-cycle glitch
    uart_rx = 1'b0;
    idle(1);
    uart_rx = 1'b1;
    idle(4 * DIV + 10);
    probe(S_RD, A_STAT, 1'b0, 8'h01, "rx_false_start");
`endif

    done_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
